// File: rtl/spi_digit_cmd.sv
// SPI command decoder for a 4-digit 7-segment display: parses framed bytes into
// digit/colon/increment/clear commands and holds the committed display state.
module spi_digit_cmd #(
    parameter logic [15:0] RESET_DIGITS = 16'h0000,
    parameter logic [1:0]  RESET_COLON  = 2'b11,
    parameter int          CS_SYNC      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [1:0] colon,
    output logic       update,
    output logic       err,
    output logic [7:0] status
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        DATA1   = 3'd2,
        DATA2   = 3'd3,
        DISCARD = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        K_DIGIT = 2'd0,
        K_COLON = 2'd1,
        K_ALL   = 2'd2
    } kind_t;

    logic [CS_SYNC-1:0] cs_sync_reg;
    logic               cs_act;
    logic               cs_act_d_reg;
    logic               cs_fall;
    logic               cs_rise;

    state_t      state_reg,  state_next;
    kind_t       kind_reg,   kind_next;
    logic [1:0]  idx_reg,    idx_next;
    logic [7:0]  shadow_reg, shadow_next;
    logic [15:0] digits_reg, digits_next;
    logic [1:0]  colon_reg,  colon_next;
    logic        err_reg,    err_next;
    logic        update_reg;
    logic        commit;

    // Synchronizer idles high so a reset never looks like a chip-select edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_reg  <= '1;
            cs_act_d_reg <= 1'b0;
        end else begin
            cs_sync_reg  <= {cs_sync_reg[CS_SYNC-2:0], cs_n};
            cs_act_d_reg <= cs_act;
        end
    end

    assign cs_act  = ~cs_sync_reg[CS_SYNC-1];
    assign cs_fall = cs_act & ~cs_act_d_reg;
    assign cs_rise = ~cs_act & cs_act_d_reg;

    // Digits ripple from the LSD; any nibble of 9 or above wraps and carries.
    function automatic logic [15:0] bcd_inc(input logic [15:0] d);
        logic [15:0] r;
        logic        carry;
        r     = d;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (d[i*4 +: 4] >= 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = d[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            kind_reg   <= K_DIGIT;
            idx_reg    <= 2'd0;
            shadow_reg <= 8'd0;
            digits_reg <= RESET_DIGITS;
            colon_reg  <= RESET_COLON;
            err_reg    <= 1'b0;
            update_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            kind_reg   <= kind_next;
            idx_reg    <= idx_next;
            shadow_reg <= shadow_next;
            digits_reg <= digits_next;
            colon_reg  <= colon_next;
            err_reg    <= err_next;
            update_reg <= commit;
        end
    end

    always_comb begin
        state_next  = state_reg;
        kind_next   = kind_reg;
        idx_next    = idx_reg;
        shadow_next = shadow_reg;
        digits_next = digits_reg;
        colon_next  = colon_reg;
        err_next    = err_reg;
        commit      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cs_fall) state_next = CMD;
            end
            CMD: begin
                if (rx_valid) begin
                    case (rx_byte)
                        8'h10, 8'h11, 8'h12, 8'h13: begin
                            kind_next  = K_DIGIT;
                            idx_next   = rx_byte[1:0];
                            state_next = DATA1;
                        end
                        8'h20: begin
                            kind_next  = K_COLON;
                            state_next = DATA1;
                        end
                        8'h30: begin
                            kind_next  = K_ALL;
                            state_next = DATA1;
                        end
                        8'h40: begin
                            digits_next = bcd_inc(digits_reg);
                            commit      = 1'b1;
                            state_next  = DISCARD;
                        end
                        8'h50: begin
                            digits_next = RESET_DIGITS;
                            colon_next  = RESET_COLON;
                            err_next    = 1'b0;
                            commit      = 1'b1;
                            state_next  = DISCARD;
                        end
                        default: begin
                            err_next   = 1'b1;
                            state_next = DISCARD;
                        end
                    endcase
                end
            end
            DATA1: begin
                if (rx_valid) begin
                    case (kind_reg)
                        K_DIGIT: begin
                            digits_next[{idx_reg, 2'b00} +: 4] = rx_byte[3:0];
                            commit     = 1'b1;
                            state_next = DISCARD;
                        end
                        K_COLON: begin
                            colon_next = rx_byte[1:0];
                            commit     = 1'b1;
                            state_next = DISCARD;
                        end
                        K_ALL: begin
                            shadow_next = rx_byte;
                            state_next  = DATA2;
                        end
                        default: state_next = DISCARD;
                    endcase
                end
            end
            DATA2: begin
                if (rx_valid) begin
                    digits_next = {shadow_reg, rx_byte};
                    commit      = 1'b1;
                    state_next  = DISCARD;
                end
            end
            DISCARD: ;
            default: state_next = IDLE;
        endcase

        // Chip-select edges win over the byte's next state, but the byte's
        // data effects above still apply in the same cycle.
        if (state_reg != IDLE) begin
            if (cs_rise)      state_next = IDLE;
            else if (cs_fall) state_next = CMD;
        end
    end

    assign digit0 = digits_reg[3:0];
    assign digit1 = digits_reg[7:4];
    assign digit2 = digits_reg[11:8];
    assign digit3 = digits_reg[15:12];
    assign colon  = colon_reg;
    assign update = update_reg;
    assign err    = err_reg;
    assign status = {err_reg, 4'b0000, state_reg};

endmodule

// File: tb/tb_spi_digit_cmd.sv
// Scoreboard bench for spi_digit_cmd: commits are predicted at stimulus time and
// checked by a monitor on every update pulse.
module tb_spi_digit_cmd;

    logic       clk;
    logic       rst_n;
    logic       cs_n;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [1:0] colon;
    logic       update;
    logic       err;
    logic [7:0] status;

    int checks = 0;
    int errors = 0;
    int updates = 0;

    // expected {digit3..digit0, colon, err}
    logic [18:0] exp_q[$];
    logic [7:0]  tx_q[$];

    spi_digit_cmd dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs_n     (cs_n),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .digit0   (digit0),
        .digit1   (digit1),
        .digit2   (digit2),
        .digit3   (digit3),
        .colon    (colon),
        .update   (update),
        .err      (err),
        .status   (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: every update pulse must match the oldest predicted commit.
    always @(negedge clk) begin
        if (rst_n && update) begin
            logic [18:0] act;
            logic [18:0] req;
            act = {digit3, digit2, digit1, digit0, colon, err};
            updates++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update: got %0h expected no update", act);
            end else begin
                req = exp_q.pop_front();
                if (act !== req) begin
                    errors++;
                    $display("FAIL commit: got %0h expected %0h", act, req);
                end else begin
                    $display("ok   commit: %0h", act);
                end
            end
        end
    end

    task automatic cs_begin();
        @(posedge clk); #1;
        cs_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic cs_end();
        cs_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic frame();
        cs_begin();
        foreach (tx_q[i]) send(tx_q[i]);
        cs_end();
    endtask

    initial begin
        rst_n    = 1'b0;
        cs_n     = 1'b1;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        check("reset_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
        check("reset_colon", colon, 2'b11);
        check("reset_err", err, 1'b0);
        check("reset_status", status, 8'h00);
        check("reset_update", update, 1'b0);

        // chip-select toggle with no bytes
        cs_begin();
        check("cs_only_state_cmd", status, 8'h01);
        cs_end();
        check("cs_only_no_update", updates, 0);
        check("cs_only_state_idle", status, 8'h00);

        // write-all; no partial update before the last byte
        cs_begin();
        send(8'h30);
        send(8'h12);
        check("partial_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
        check("partial_state_data2", status, 8'h03);
        exp_q.push_back({16'h1234, 2'b11, 1'b0});
        send(8'h34);
        cs_end();
        check("write_all_digits", {digit3, digit2, digit1, digit0}, 16'h1234);
        check("write_all_one_update", updates, 1);

        // aborted write-all
        tx_q = '{8'h30, 8'h56};
        frame();
        check("abort_digits", {digit3, digit2, digit1, digit0}, 16'h1234);
        check("abort_status", status, 8'h00);
        check("abort_no_update", updates, 1);

        // BCD increment wrap 9999 -> 0000
        exp_q.push_back({16'h9999, 2'b11, 1'b0});
        tx_q = '{8'h30, 8'h99, 8'h99};
        frame();
        exp_q.push_back({16'h0000, 2'b11, 1'b0});
        tx_q = '{8'h40};
        frame();

        // hex digit ripple: 0A19 -> 0A20
        exp_q.push_back({16'h0A19, 2'b11, 1'b0});
        tx_q = '{8'h30, 8'h0A, 8'h19};
        frame();
        exp_q.push_back({16'h0A20, 2'b11, 1'b0});
        tx_q = '{8'h40};
        frame();

        // hex digit at/above 9 carries: 0A99 -> 1000
        exp_q.push_back({16'h0A99, 2'b11, 1'b0});
        tx_q = '{8'h30, 8'h0A, 8'h99};
        frame();
        exp_q.push_back({16'h1000, 2'b11, 1'b0});
        tx_q = '{8'h40};
        frame();

        // bad command sets sticky err
        tx_q = '{8'h7E};
        frame();
        check("bad_cmd_err", err, 1'b1);
        check("bad_cmd_status", status, 8'h80);

        // single digit write keeps err
        exp_q.push_back({16'h1070, 2'b11, 1'b1});
        tx_q = '{8'h11, 8'h07};
        frame();
        check("digit1_err_sticky", err, 1'b1);

        // clear
        exp_q.push_back({16'h0000, 2'b11, 1'b0});
        tx_q = '{8'h50};
        frame();
        check("clear_status", status, 8'h00);

        // digit3 write, trailing byte discarded without error
        exp_q.push_back({16'h5000, 2'b11, 1'b0});
        tx_q = '{8'h13, 8'h05, 8'hFF};
        frame();
        check("discard_no_err", err, 1'b0);

        // colon byte coincides with chip-select release
        cs_begin();
        send(8'h20);
        cs_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back({16'h5000, 2'b00, 1'b0});
        rx_byte  = 8'h00;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        check("coincident_state_idle", status, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("coincident_colon", colon, 2'b00);

        // mid-frame asynchronous reset
        tx_q = '{8'h7E};
        frame();
        cs_begin();
        send(8'h30);
        send(8'h12);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
        check("async_rst_colon", colon, 2'b11);
        check("async_rst_err", err, 1'b0);
        check("async_rst_status", status, 8'h00);
        check("async_rst_update", update, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cs_end();

        check("all_commits_seen", exp_q.size(), 0);
        check("total_updates", updates, 11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
